// File: rtl/apb_master_mc_if.sv
// Request/response handshake and APB4 bus bundle for apb_master_mc.
// Latency: none, wiring only.
// Backpressure: req_ready gates requests; the APB side stalls on PREADY.
//
// Signal summary:
//   request  : req_valid/req_ready, req_write, req_slv, req_addr, req_wdata, req_strb
//   response : rsp_valid (one-cycle pulse), rsp_rdata, rsp_err
//   APB      : PADDR, PSEL (one-hot), PENABLE, PWRITE, PWDATA, PSTRB, PRDATA, PREADY, PSLVERR
// Modports: master = the bus master's view, slave = the view of requester + peripherals.
interface apb_master_mc_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 4
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_write;
    logic [3:0]                req_slv;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic [DATA_WIDTH-1:0]     req_wdata;
    logic [DATA_WIDTH/8-1:0]   req_strb;

    logic                      rsp_valid;
    logic [DATA_WIDTH-1:0]     rsp_rdata;
    logic                      rsp_err;

    logic [ADDR_WIDTH-1:0]     PADDR;
    logic [NUM_SLAVES-1:0]     PSEL;
    logic                      PENABLE;
    logic                      PWRITE;
    logic [DATA_WIDTH-1:0]     PWDATA;
    logic [DATA_WIDTH/8-1:0]   PSTRB;
    logic [DATA_WIDTH-1:0]     PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        input  req_valid, req_write, req_slv, req_addr, req_wdata, req_strb,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output req_valid, req_write, req_slv, req_addr, req_wdata, req_strb,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_master_mc.sv
// Parametrised APB4 master: one request at a time, IDLE->SETUP->ACCESS, one-hot PSEL.
// Latency: rsp_valid 3 cycles after accept with zero wait states (2 for a decode error).
// Backpressure: req_ready high only in IDLE; ACCESS stalls on PREADY (bounded by the optional timeout).
//
// Ports: PCLK, PRESETn (async active-low) and bus (apb_master_mc_if.master) carrying the
//        request handshake, the one-cycle response strobe and the APB4 signals.
// Option: define APB_MST_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES cycles without PREADY.
//         Without it no counter is built and ACCESS waits indefinitely.
module apb_master_mc #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic           PCLK,
    input  logic           PRESETn,
    apb_master_mc_if.master bus
);

    // Elaboration-time parameter sanity checks.
    if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32)) begin : g_bad_dw
        $error("apb_master_mc: DATA_WIDTH must be 8, 16 or 32");
    end
    if (NUM_SLAVES < 1 || NUM_SLAVES > 16) begin : g_bad_ns
        $error("apb_master_mc: NUM_SLAVES must be 1..16");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_to
        $error("apb_master_mc: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DECERR} state_t;

    // req_slv is 4 bits wide; compare on 5 bits so NUM_SLAVES = 16 works.
    localparam logic [4:0]            NSLV     = 5'(NUM_SLAVES);
    localparam logic [NUM_SLAVES-1:0] PSEL_ONE = NUM_SLAVES'(1);

    state_t state;

`ifdef APB_MST_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] acc_cnt;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state         <= IDLE;
            bus.req_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            bus.PADDR     <= '0;
            bus.PSEL      <= '0;
            bus.PENABLE   <= 1'b0;
            bus.PWRITE    <= 1'b0;
            bus.PWDATA    <= '0;
            bus.PSTRB     <= '0;
`ifdef APB_MST_TIMEOUT_EN
            acc_cnt       <= '0;
`endif
        end else begin
            // Response fields are zero except on the single completion cycle.
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;

            case (state)
                IDLE: begin
                    // req_ready comes up on the first edge after reset release.
                    bus.req_ready <= 1'b1;
                    if (bus.req_valid && bus.req_ready) begin
                        bus.req_ready <= 1'b0;
                        if ({1'b0, bus.req_slv} < NSLV) begin
                            bus.PADDR   <= bus.req_addr;
                            bus.PWRITE  <= bus.req_write;
                            bus.PWDATA  <= bus.req_wdata;
                            bus.PSTRB   <= bus.req_write ? bus.req_strb : '0;
                            bus.PSEL    <= PSEL_ONE << bus.req_slv;
                            bus.PENABLE <= 1'b0;
`ifdef APB_MST_TIMEOUT_EN
                            acc_cnt     <= '0;
`endif
                            state       <= SETUP;
                        end else begin
                            // Out-of-range slave: no bus cycle, just an error response.
                            state <= DECERR;
                        end
                    end
                end

                SETUP: begin
                    bus.PENABLE <= 1'b1;
                    state       <= ACCESS;
                end

                ACCESS: begin
                    if (bus.PREADY) begin
                        // PRDATA/PSLVERR are only meaningful on this cycle.
                        bus.PSEL      <= '0;
                        bus.PENABLE   <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= bus.PSLVERR;
                        bus.rsp_rdata <= bus.PWRITE ? '0 : bus.PRDATA;
                        bus.req_ready <= 1'b1;
                        state         <= IDLE;
                    end
`ifdef APB_MST_TIMEOUT_EN
                    // acc_cnt counts completed ACCESS cycles, so the last
                    // permitted cycle is the one where it equals limit-1.
                    else if (acc_cnt == CNT_LAST) begin
                        bus.PSEL      <= '0;
                        bus.PENABLE   <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b1;
                        bus.req_ready <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        acc_cnt <= acc_cnt + 1'b1;
                    end
`endif
                end

                DECERR: begin
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_err   <= 1'b1;
                    bus.req_ready <= 1'b1;
                    state         <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_mc.sv
// Self-checking bench for apb_master_mc (32-bit data, 4 slaves, TIMEOUT_CYCLES = 8).
// Latency: n/a.
// Backpressure: n/a.
module tb_apb_master_mc;

    logic PCLK;
    logic PRESETn;

    apb_master_mc_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(4)) bus ();

    apb_master_mc #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;
    rsp_t sb_q[$];

    task automatic push_exp(input logic [31:0] rdata, input logic err);
        rsp_t e;
        e.rdata = rdata;
        e.err   = err;
        sb_q.push_back(e);
    endtask

    // An empty scoreboard yields X so the following compare reports it.
    task automatic pop_exp(output rsp_t e);
        if (sb_q.size() == 0) begin
            e.rdata = 'x;
            e.err   = 1'bx;
        end else begin
            e = sb_q.pop_front();
        end
    endtask

    task automatic drive_req(input logic w, input logic [3:0] slv, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] s);
        bus.req_write = w;
        bus.req_slv   = slv;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_strb  = s;
        bus.req_valid = 1'b1;
    endtask

    // Called at a negedge: present request, let the next posedge accept it, then drop it.
    task automatic accept_req(input logic w, input logic [3:0] slv, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] s);
        drive_req(w, slv, a, d, s);
        @(posedge PCLK);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rsp_t e;
        PRESETn = 1'b0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_slv = '0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.req_strb = '0;
        bus.PRDATA = '0; bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
        repeat (2) @(negedge PCLK);
        checks++; if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.PENABLE, bus.PWRITE} !== 5'b0) begin
            failures++; $display("FAIL rst_ctrl got=%b exp=00000", {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.PENABLE, bus.PWRITE}); end
        checks++; if ({bus.PADDR, bus.PWDATA, bus.rsp_rdata, bus.PSEL, bus.PSTRB} !== '0) begin
            failures++; $display("FAIL rst_data got=%h/%h/%h/%h/%h exp=0", bus.PADDR, bus.PWDATA, bus.rsp_rdata, bus.PSEL, bus.PSTRB); end
        PRESETn = 1'b1;
        @(negedge PCLK);
        checks++; if (bus.req_ready !== 1'b1) begin
            failures++; $display("FAIL rst_release_ready got=%b exp=1", bus.req_ready); end
        e.err = 1'b0;
    endtask

    task automatic test_write();
        rsp_t e;
        bus.PREADY = 1'b1; bus.PSLVERR = 1'b0; bus.PRDATA = 32'h1234_5678;
        checks++; if (bus.req_ready !== 1'b1) begin
            failures++; $display("FAIL wr_ready got=%b exp=1", bus.req_ready); end
        push_exp(32'h0, 1'b0);
        accept_req(1'b1, 4'd1, 32'h10, 32'hA5A5_0001, 4'hF);
        @(negedge PCLK); // SETUP
        checks++; if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PSTRB, bus.req_ready} !== {4'b0010, 1'b0, 1'b1, 4'hF, 1'b0}) begin
            failures++; $display("FAIL wr_setup got=%b_%b_%b_%h_%b exp=0010_0_1_f_0", bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PSTRB, bus.req_ready); end
        checks++; if ({bus.PADDR, bus.PWDATA} !== {32'h10, 32'hA5A5_0001}) begin
            failures++; $display("FAIL wr_setup_addr_data got=%h_%h exp=00000010_a5a50001", bus.PADDR, bus.PWDATA); end
        @(negedge PCLK); // ACCESS
        checks++; if ({bus.PSEL, bus.PENABLE, bus.rsp_valid} !== {4'b0010, 1'b1, 1'b0}) begin
            failures++; $display("FAIL wr_access got=%b_%b_%b exp=0010_1_0", bus.PSEL, bus.PENABLE, bus.rsp_valid); end
        @(negedge PCLK); // response cycle, 3 after accept
        pop_exp(e);
        checks++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {1'b1, e.err, e.rdata}) begin
            failures++; $display("FAIL wr_rsp got=%b_%b_%h exp=1_%b_%h", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, e.err, e.rdata); end
        checks++; if ({bus.PSEL, bus.PENABLE, bus.req_ready} !== {4'b0000, 1'b0, 1'b1}) begin
            failures++; $display("FAIL wr_done_bus got=%b_%b_%b exp=0000_0_1", bus.PSEL, bus.PENABLE, bus.req_ready); end
        @(negedge PCLK);
        checks++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== 34'b0) begin
            failures++; $display("FAIL wr_rsp_pulse got=%b_%b_%h exp=0_0_0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
        checks++; if ({bus.PADDR, bus.PWDATA, bus.PSTRB, bus.PWRITE} !== {32'h10, 32'hA5A5_0001, 4'hF, 1'b1}) begin
            failures++; $display("FAIL wr_hold_after got=%h_%h_%h_%b exp=00000010_a5a50001_f_1", bus.PADDR, bus.PWDATA, bus.PSTRB, bus.PWRITE); end
    endtask

    task automatic test_read_wait();
        rsp_t e;
        int bad;
        // Junk on PRDATA/PSLVERR while PREADY is low must be ignored.
        bus.PREADY = 1'b0; bus.PSLVERR = 1'b1; bus.PRDATA = 32'h1111_1111;
        push_exp(32'hDEAD_BEEF, 1'b0);
        accept_req(1'b0, 4'd0, 32'h20, 32'hFFFF_FFFF, 4'hF);
        @(negedge PCLK); // SETUP
        checks++; if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PSTRB} !== {4'b0001, 1'b0, 1'b0, 4'h0}) begin
            failures++; $display("FAIL rd_setup got=%b_%b_%b_%h exp=0001_0_0_0", bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PSTRB); end
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge PCLK);
            if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PSTRB, bus.rsp_valid} !== {4'b0001, 1'b1, 1'b0, 4'h0, 1'b0} || bus.PADDR !== 32'h20) bad++;
            if (i == 3) begin
                bus.PREADY = 1'b1; bus.PSLVERR = 1'b0; bus.PRDATA = 32'hDEAD_BEEF;
            end
        end
        checks++; if (bad !== 0) begin
            failures++; $display("FAIL rd_wait_stable got=%0d bad cycles exp=0", bad); end
        @(negedge PCLK);
        bus.PRDATA = 32'h2222_2222;
        pop_exp(e);
        checks++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {1'b1, e.err, e.rdata}) begin
            failures++; $display("FAIL rd_rsp got=%b_%b_%h exp=1_%b_%h", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, e.err, e.rdata); end
        @(negedge PCLK);
    endtask

    task automatic test_slverr();
        rsp_t e;
        bus.PREADY = 1'b1; bus.PSLVERR = 1'b1; bus.PRDATA = 32'hFFFF_0000;
        push_exp(32'h0, 1'b1);
        accept_req(1'b1, 4'd2, 32'h44, 32'h0BAD_F00D, 4'h3);
        @(negedge PCLK);
        checks++; if ({bus.PSEL, bus.PSTRB} !== {4'b0100, 4'h3}) begin
            failures++; $display("FAIL err_setup got=%b_%h exp=0100_3", bus.PSEL, bus.PSTRB); end
        repeat (2) @(negedge PCLK);
        pop_exp(e);
        checks++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {1'b1, e.err, e.rdata}) begin
            failures++; $display("FAIL err_rsp got=%b_%b_%h exp=1_%b_%h", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, e.err, e.rdata); end
        bus.PSLVERR = 1'b0;
        @(negedge PCLK);
    endtask

    task automatic test_decerr();
        rsp_t e;
        bus.PREADY = 1'b1; bus.PRDATA = 32'h5555_AAAA;
        push_exp(32'h0, 1'b1);
        accept_req(1'b0, 4'd5, 32'h80, 32'h0, 4'h0);
        @(negedge PCLK);
        checks++; if ({bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.req_ready} !== {4'b0000, 1'b0, 1'b0, 1'b0}) begin
            failures++; $display("FAIL dec_first got=%b_%b_%b_%b exp=0000_0_0_0", bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.req_ready); end
        @(negedge PCLK); // 2 cycles after accept
        pop_exp(e);
        checks++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.PSEL} !== {1'b1, e.err, e.rdata, 4'b0000}) begin
            failures++; $display("FAIL dec_rsp got=%b_%b_%h_%b exp=1_%b_%h_0000", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.PSEL, e.err, e.rdata); end
        @(negedge PCLK);
    endtask

    task automatic test_back_to_back();
        rsp_t e;
        int bad;
        bus.PREADY = 1'b1; bus.PSLVERR = 1'b0; bus.PRDATA = 32'hCAFE_0003;
        push_exp(32'h0, 1'b0);
        push_exp(32'hCAFE_0003, 1'b0);
        drive_req(1'b1, 4'd3, 32'h100, 32'h0000_00AA, 4'h1);
        @(posedge PCLK);
        @(negedge PCLK); // SETUP of A; present B while busy, must be ignored
        drive_req(1'b0, 4'd1, 32'h200, 32'h0, 4'hF);
        bad = 0;
        for (int i = 0; i < 2; i++) begin
            if (bus.PADDR !== 32'h100 || bus.PSEL !== 4'b1000 || bus.PWRITE !== 1'b1) bad++;
            @(negedge PCLK);
        end
        checks++; if (bad !== 0) begin
            failures++; $display("FAIL b2b_ignore_busy got=%0d bad cycles exp=0", bad); end
        pop_exp(e); // response of A; B is accepted at the next edge
        checks++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.req_ready} !== {1'b1, e.err, e.rdata, 1'b1}) begin
            failures++; $display("FAIL b2b_rsp_a got=%b_%b_%h_%b exp=1_%b_%h_1", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.req_ready, e.err, e.rdata); end
        @(posedge PCLK);
        #1 bus.req_valid = 1'b0;
        @(negedge PCLK);
        checks++; if ({bus.PADDR, bus.PSEL, bus.PENABLE, bus.PWRITE} !== {32'h200, 4'b0010, 1'b0, 1'b0}) begin
            failures++; $display("FAIL b2b_setup_b got=%h_%b_%b_%b exp=00000200_0010_0_0", bus.PADDR, bus.PSEL, bus.PENABLE, bus.PWRITE); end
        repeat (2) @(negedge PCLK);
        pop_exp(e);
        checks++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {1'b1, e.err, e.rdata}) begin
            failures++; $display("FAIL b2b_rsp_b got=%b_%b_%h exp=1_%b_%h", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, e.err, e.rdata); end
        @(negedge PCLK);
    endtask

    task automatic test_reset_mid();
        int rsp_seen;
        bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
        accept_req(1'b0, 4'd2, 32'h300, 32'h0, 4'h0); // no response expected
        repeat (2) @(negedge PCLK);
        checks++; if ({bus.PSEL, bus.PENABLE} !== {4'b0100, 1'b1}) begin
            failures++; $display("FAIL rm_access got=%b_%b exp=0100_1", bus.PSEL, bus.PENABLE); end
        #1 PRESETn = 1'b0;
        #1;
        checks++; if ({bus.PSEL, bus.PENABLE} !== {4'b0000, 1'b0}) begin
            failures++; $display("FAIL rm_async_drop got=%b_%b exp=0000_0", bus.PSEL, bus.PENABLE); end
        bus.PREADY = 1'b1; bus.PRDATA = 32'h7777_7777;
        @(negedge PCLK);
        PRESETn = 1'b1;
        rsp_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge PCLK);
            if (bus.rsp_valid === 1'b1) rsp_seen++;
            if (i == 0) begin
                checks++; if (bus.req_ready !== 1'b1) begin
                    failures++; $display("FAIL rm_ready_after got=%b exp=1", bus.req_ready); end
            end
        end
        checks++; if (rsp_seen !== 0) begin
            failures++; $display("FAIL rm_no_rsp got=%0d pulses exp=0", rsp_seen); end
    endtask

    task automatic test_timeout();
        rsp_t e;
        int bad;
        int n;
        bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
        accept_req(1'b1, 4'd3, 32'h400, 32'h1357_9BDF, 4'hC);
        @(negedge PCLK); // SETUP
`ifdef APB_MST_TIMEOUT_EN
        push_exp(32'h0, 1'b1);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge PCLK);
            if ({bus.PSEL, bus.PENABLE, bus.rsp_valid} !== {4'b1000, 1'b1, 1'b0}) bad++;
        end
        checks++; if (bad !== 0) begin
            failures++; $display("FAIL to_wait got=%0d bad cycles exp=0", bad); end
        @(negedge PCLK);
        pop_exp(e);
        checks++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.PSEL, bus.PENABLE} !== {1'b1, e.err, e.rdata, 4'b0000, 1'b0}) begin
            failures++; $display("FAIL to_abort got=%b_%b_%h_%b_%b exp=1_%b_%h_0000_0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.PSEL, bus.PENABLE, e.err, e.rdata); end
        n = 0;
`else
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge PCLK);
            if ({bus.PSEL, bus.PENABLE, bus.rsp_valid} !== {4'b1000, 1'b1, 1'b0}) bad++;
        end
        checks++; if (bad !== 0) begin
            failures++; $display("FAIL nto_hold got=%0d bad cycles exp=0", bad); end
        push_exp(32'h0, 1'b0);
        bus.PREADY = 1'b1;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 5) begin
            @(negedge PCLK);
            n++;
        end
        pop_exp(e);
        checks++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {1'b1, e.err, e.rdata} || n !== 1) begin
            failures++; $display("FAIL nto_release got=%b_%b_%h after %0d exp=1_%b_%h after 1", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, n, e.err, e.rdata); end
`endif
        @(negedge PCLK);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_slverr();
        test_decerr();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        checks++; if (sb_q.size() !== 0) begin
            failures++; $display("FAIL sb_leftover got=%0d exp=0", sb_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/apb_master_mc.md
Name: apb_master_mc

Overview:
- Parametrised APB4 master; next generation of the team's single-slave, fixed-32-bit APB master FSM.
- Accepts one request at a time on a valid/ready request port and drives a standard IDLE→SETUP→ACCESS transfer.
- Supports wait states via PREADY, slave errors via PSLVERR, byte strobes and NUM_SLAVES one-hot PSEL lines.
- Returns read data and error status on a one-cycle response strobe; sits between the AHB-side bridge logic and the peripheral bus.

Parameters:
- ADDR_WIDTH, 32, width of req_addr and PADDR.
- DATA_WIDTH, 32, width of data buses; must be 8, 16 or 32.
- NUM_SLAVES, 4, number of PSEL lines (1..16).
- TIMEOUT_CYCLES, 256, ACCESS-cycle limit; used only when APB_MST_TIMEOUT_EN is defined.

Ports:
- PCLK  in  1  clock.
- PRESETn  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  master can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_slv  in  4  target slave index.
- req_addr  in  ADDR_WIDTH  target address.
- req_wdata  in  DATA_WIDTH  write data.
- req_strb  in  DATA_WIDTH/8  write byte strobes.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_err  out  1  error flag (PSLVERR, decode error, or timeout).
- PADDR  out  ADDR_WIDTH  APB address.
- PSEL  out  NUM_SLAVES  one-hot slave select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_WIDTH  APB write data.
- PSTRB  out  DATA_WIDTH/8  APB write strobes.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY  in  1  slave ready.
- PSLVERR  in  1  slave error.

Behaviour:
- Reset: every output is registered; PRESETn low asynchronously clears all outputs to 0 and the state to IDLE.
- States: IDLE, SETUP, ACCESS, DECERR.
- req_ready = 1 only in IDLE. A request is accepted at a rising edge where req_valid & req_ready.
- On accept with req_slv < NUM_SLAVES:
  - Latch PADDR, PWRITE and PWDATA.
  - PSTRB = req_strb on writes, all-zero on reads.
  - PSEL[req_slv] = 1, PENABLE = 0; go to SETUP.
- On accept with req_slv >= NUM_SLAVES: go to DECERR; no PSEL is asserted.
- SETUP, one cycle: PENABLE = 1 at the next edge; go to ACCESS.
- ACCESS: hold all APB outputs stable while PREADY = 0 (unlimited wait states by default).
- ACCESS completion, at an edge with PREADY = 1:
  - PSEL and PENABLE go to 0.
  - rsp_valid = 1 for exactly one cycle.
  - rsp_err = PSLVERR.
  - rsp_rdata = PRDATA for reads, 0 for writes.
  - Return to IDLE.
- DECERR: one cycle, then rsp_valid = 1, rsp_err = 1, rsp_rdata = 0; return to IDLE.
- Latency: zero-wait transfer runs accept edge → SETUP cycle → ACCESS cycle → rsp_valid in the following cycle (3 cycles after accept).
  - req_ready is high in the same cycle as rsp_valid, so the next SETUP can begin 1 cycle later.
- PSLVERR and PRDATA are sampled only in ACCESS with PREADY = 1 and are ignored otherwise.
- rsp_rdata and rsp_err are 0 whenever rsp_valid = 0.
- PADDR, PWRITE, PWDATA and PSTRB keep their last values after a transfer until the next accept.
- Request inputs are ignored while req_ready = 0.
- Reset mid-transfer: PSEL and PENABLE drop immediately; no rsp_valid is generated for the aborted transfer.

Optional Feature:
- Macro: APB_MST_TIMEOUT_EN.
- Defined:
  - A counter of ACCESS cycles runs, cleared on entry to SETUP.
  - If the count reaches TIMEOUT_CYCLES with PREADY still 0, the transfer aborts: PSEL and PENABLE go to 0, rsp_valid = 1, rsp_err = 1, rsp_rdata = 0, state returns to IDLE.
  - PREADY = 1 on the same cycle the limit is reached takes priority; the transfer completes normally.
- Not defined: no counter logic is built; ACCESS waits on PREADY indefinitely.

Test Plan:
- Write, req_slv = 1, addr 0x10, wdata 0xA5A5_0001, strb 0xF, PREADY tied to 1 → PSEL = 4'b0010 in SETUP and ACCESS, PENABLE high 1 cycle, PSTRB = 0xF; rsp_valid 3 cycles after accept, rsp_err = 0.
- Read, req_slv = 0, addr 0x20, PREADY held low for 3 ACCESS cycles, PRDATA = 0xDEAD_BEEF → APB outputs stable for 4 ACCESS cycles, PSTRB = 0; rsp_rdata = 0xDEAD_BEEF.
- Write with PSLVERR = 1 at the PREADY cycle → rsp_err = 1, rsp_rdata = 0.
- req_slv = 5 with NUM_SLAVES = 4 → PSEL stays 0; rsp_valid with rsp_err = 1 2 cycles after accept.
- PRESETn pulled low during ACCESS → PSEL and PENABLE are 0 before the next PCLK edge; no rsp_valid; req_ready = 1 after reset release.
- APB_MST_TIMEOUT_EN defined, TIMEOUT_CYCLES = 8, PREADY stuck at 0 → abort after 8 ACCESS cycles with rsp_err = 1. Without the macro, the same stimulus leaves PSEL and PENABLE held at 1 indefinitely.
